uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4618, meaning clk cycles per serial bit (44.33 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  system clock from internal oscillator; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_UART_TX  input  1  asynchronous serial line from FT2232, idle high, 8N1, LSB first.
REQ-006 SHALL have port i_rd  input  1  one-cycle pop strobe from 6809 data-register read.
REQ-007 SHALL have port i_clr_err  input  1  one-cycle clear of sticky error flags.
REQ-008 SHALL have port i_irq_en  input  1  receive-interrupt enable.
REQ-009 SHALL have port o_data  output  8  FIFO head byte, first-word-fall-through.
REQ-010 SHALL have port o_rx_ready  output  1  FIFO not empty.
REQ-011 SHALL have port o_count  output  log2(FIFO_DEPTH)+1  bytes held.
REQ-012 SHALL have port o_overrun  output  1  sticky: byte dropped on full FIFO.
REQ-013 SHALL have port o_frame_err  output  1  sticky: stop bit sampled low.
REQ-014 SHALL have port o_irq  output  1  o_rx_ready AND i_irq_en, registered.

Function
REQ-015 SHALL pass i_UART_TX through a two-flop synchronizer; all decisions use the synchronized value and a one-cycle-delayed copy.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, driven by one bit-timing counter 0..CLKS_PER_BIT-1.
REQ-017 IDLE: on synchronized falling edge, SHALL clear counter and enter START.
REQ-018 START: at count CLKS_PER_BIT/2 (integer division) SHALL sample; low -> DATA with counter cleared and bit index 0; high -> IDLE (glitch rejected, nothing pushed).
REQ-019 DATA: every CLKS_PER_BIT cycles SHALL shift the sample into bit[index]; after index 7 -> STOP.
REQ-020 STOP: after CLKS_PER_BIT cycles SHALL sample the stop bit, act per REQ-030/031, and return to IDLE in the same cycle.
REQ-021 A completed byte SHALL be visible on o_data with o_rx_ready high on the cycle after the stop-bit sample when the FIFO was empty.
REQ-022 Pop: i_rd with FIFO non-empty SHALL advance the head next cycle; i_rd on empty SHALL be ignored with no state change.
REQ-023 Push on full without simultaneous pop SHALL drop the byte, keep FIFO contents, and set o_overrun.
REQ-024 Simultaneous push and pop SHALL both succeed, count unchanged, including when full (no overrun).
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; o_count SHALL reach exactly FIFO_DEPTH when full.
REQ-026 i_clr_err SHALL clear o_overrun and o_frame_err next cycle; a new error in the same cycle SHALL win (flag stays set).
REQ-027 A line held low SHALL NOT generate repeated bytes; a new frame requires a fresh falling edge after IDLE is re-entered.

Reset
REQ-028 On reset SHALL enter IDLE, empty the FIFO, zero pointers, counters and o_count, clear o_overrun, o_frame_err, o_irq, drive o_data 8'h00 and o_rx_ready 0, and set both synchronizer flops and the delayed copy to 1, so a line low at reset release is not taken as a start bit.
REQ-029 Reset mid-frame SHALL abandon the partial byte; no push.

Configuration
REQ-030 With macro UART_RX_FRAMING_CHECK_EN defined, a low stop bit SHALL discard the byte and set o_frame_err; a high stop bit pushes the byte.
REQ-031 Without UART_RX_FRAMING_CHECK_EN, every frame SHALL be pushed regardless of stop bit, and o_frame_err SHALL be tied 0.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-032 Send 0xA5 with a good stop bit -> o_rx_ready high 1 cycle after stop sample, o_data=0xA5, o_count=1; i_rd -> o_count=0, o_rx_ready=0.
REQ-033 Send 0x01,0x02,0x03,0x04,0x05 without reads -> o_count=4, o_overrun=1, pops return 0x01..0x04; i_clr_err -> o_overrun=0.
REQ-034 FIFO full, pop strobed on the stop-sample cycle of 0x55 -> o_count stays 4, o_overrun=0, last entry 0x55.
REQ-035 6-cycle low glitch on idle line -> no push, state back to IDLE, o_count=0.
REQ-036 Send 0x3C with stop bit low: macro defined -> o_count=0, o_frame_err=1; macro undefined -> 0x3C pushed, o_frame_err=0.
REQ-037 Assert reset during DATA bit 4, line held low through release -> o_count=0, flags 0, no byte until line returns high and a new start arrives.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with sticky error flags.
// Define UART_RX_FRAMING_CHECK_EN to drop frames whose stop bit is low and flag them on o_frame_err.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 4618,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_UART_TX,
   input  logic                          i_rd,
   input  logic                          i_clr_err,
   input  logic                          i_irq_en,
   output logic [7:0]                    o_data,
   output logic                          o_rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_overrun,
   output logic                          o_frame_err,
   output logic                          o_irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic          r_sync1, r_sync2, r_sync_d;
   logic [1:0]    r_prime;
   logic          r_armed;
   state_t        r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic [2:0]    r_idx, w_idx_next;
   logic [7:0]    r_shift, w_shift_next;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overrun, r_irq;

   logic w_fall, w_stop_sample, w_push, w_frame_set;
   logic w_full, w_empty, w_do_push, w_do_pop;

   // Arm only after the synchronized line has been seen high post-reset, so a
   // line already low at reset release cannot masquerade as a start edge.
   assign w_fall = r_armed & r_sync_d & ~r_sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sync_d <= 1'b1;
         r_prime  <= 2'b00;
         r_armed  <= 1'b0;
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
      end else begin
         r_sync1  <= i_UART_TX;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
         r_prime  <= {r_prime[0], 1'b1};
         r_armed  <= r_armed | (r_prime[1] & r_sync2);
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_idx    <= w_idx_next;
         r_shift  <= w_shift_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt + CW'(1);
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            if (w_fall) w_state_next = S_START;
         end
         S_START: begin
            if (r_cnt == HALF_CNT) begin
               w_cnt_next   = '0;
               w_idx_next   = '0;
               w_state_next = r_sync2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == LAST_CNT) begin
               w_cnt_next          = '0;
               w_shift_next[r_idx] = r_sync2;
               w_idx_next          = r_idx + 3'd1;
               if (r_idx == 3'd7) w_state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (r_cnt == LAST_CNT) begin
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_stop_sample = (r_state == S_STOP) && (r_cnt == LAST_CNT);
`ifdef UART_RX_FRAMING_CHECK_EN
      w_push      = w_stop_sample & r_sync2;
      w_frame_set = w_stop_sample & ~r_sync2;
`else
      w_push      = w_stop_sample;
      w_frame_set = 1'b0;
`endif
   end

   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_rd & ~w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign w_do_push = w_push & (~w_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= r_shift;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + ONE_CNT;
            2'b01:   r_count <= r_count - ONE_CNT;
            default: r_count <= r_count;
         endcase
         r_overrun <= (r_overrun & ~i_clr_err) | (w_push & w_full & ~w_do_pop);
         r_irq     <= ~w_empty & i_irq_en;
      end
   end

`ifdef UART_RX_FRAMING_CHECK_EN
   logic r_frame_err;
   always_ff @(posedge clk) begin
      if (reset) r_frame_err <= 1'b0;
      else       r_frame_err <= (r_frame_err & ~i_clr_err) | w_frame_set;
   end
   assign o_frame_err = r_frame_err;
`else
   assign o_frame_err = w_frame_set;
`endif

   assign o_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign o_rx_ready = ~w_empty;
   assign o_count    = r_count;
   assign o_overrun  = r_overrun;
   assign o_irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: serial frames are generated bit by bit and the
// receive side is predicted with a byte queue plus two sticky flags.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
`ifdef UART_RX_FRAMING_CHECK_EN
   localparam bit FRAMING = 1'b1;
`else
   localparam bit FRAMING = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx = 1'b1;
   logic       rd = 1'b0;
   logic       clr = 1'b0;
   logic       irq_en = 1'b0;
   logic [7:0] data;
   logic       rdy, ovr, ferr, irq;
   logic [2:0] cnt;

   int total = 0;
   int bad   = 0;

   byte unsigned q[$];
   bit           m_ovr = 1'b0;
   bit           m_ferr = 1'b0;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .i_UART_TX(tx), .i_rd(rd), .i_clr_err(clr),
      .i_irq_en(irq_en), .o_data(data), .o_rx_ready(rdy), .o_count(cnt),
      .o_overrun(ovr), .o_frame_err(ferr), .o_irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_state(input string tag);
      check({tag, ":count"}, 32'(cnt), 32'(q.size()));
      check({tag, ":ready"}, 32'(rdy), 32'(q.size() != 0));
      check({tag, ":data"}, 32'(data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
      check({tag, ":overrun"}, 32'(ovr), 32'(m_ovr));
      check({tag, ":frame_err"}, 32'(ferr), 32'(m_ferr));
   endtask

   // Frame timing: start edge driven on negedge n0; the stop bit is sampled on the
   // cycle between posedges 155 and 156, so the result is visible from negedge 156.
   task automatic send_frame(input byte unsigned b, input bit stop, input bit pop_at_stop,
                             input bit clr_at_stop);
      bit [9:0] bits;
      bit       was_ready;
      bits = {stop, b, 1'b0};
      @(negedge clk);
      for (int k = 0; k < 160; k++) begin
         if (k % 16 == 0) tx = bits[k / 16];
         if (k == 155) begin
            was_ready = (q.size() != 0);
            check("ready_before_stop", 32'(rdy), 32'(was_ready));
            if (pop_at_stop && q.size() != 0) check("head_at_stop", 32'(data), 32'(q[0]));
            rd  = pop_at_stop;
            clr = clr_at_stop;
         end
         if (k == 156) begin
            rd  = 1'b0;
            clr = 1'b0;
            if (clr_at_stop) begin
               m_ovr  = 1'b0;
               m_ferr = 1'b0;
            end
            if (pop_at_stop && q.size() != 0) void'(q.pop_front());
            if (stop || !FRAMING) begin
               if (q.size() < DEPTH) q.push_back(b);
               else m_ovr = 1'b1;
            end else begin
               m_ferr = 1'b1;
            end
            expect_state("frame");
            $display("frame byte=%02h stop=%0d pop=%0d clr=%0d count=%0d ovr=%0d ferr=%0d",
                     b, stop, pop_at_stop, clr_at_stop, cnt, ovr, ferr);
         end
         @(negedge clk);
      end
      tx = 1'b1;
      tick(4);
   endtask

   task automatic pop_one();
      if (q.size() != 0) check("pop_head", 32'(data), 32'(q[0]));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      expect_state("pop");
      $display("pop count=%0d data=%02h", cnt, data);
   endtask

   task automatic clear_errs();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      expect_state("clr");
      $display("clear errors ovr=%0d ferr=%0d", ovr, ferr);
   endtask

   task automatic irq_probe(input bit en);
      irq_en = en;
      tick(2);
      check("irq", 32'(irq), 32'((q.size() != 0) && en));
      $display("irq probe en=%0d irq=%0d", en, irq);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      q.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
   endtask

   initial begin
      irq_en = 1'b1;
      tick(4);
      reset = 1'b0;
      @(negedge clk);
      expect_state("reset");
      check("reset:irq", 32'(irq), 32'h0);
      tick(6);

      // single byte, ready one cycle after stop sample
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check("a5:data", 32'(data), 32'hA5);
      tick(2);
      check("a5:irq", 32'(irq), 32'h1);
      pop_one();
      irq_probe(1'b1);

      // overflow: fifth byte dropped
      for (int i = 1; i <= 5; i++) send_frame(byte'(i), 1'b1, 1'b0, 1'b0);
      check("ovf:overrun", 32'(ovr), 32'h1);
      for (int i = 1; i <= 4; i++) begin
         check("ovf:pop_val", 32'(data), 32'(i));
         pop_one();
      end
      clear_errs();

      // full FIFO with pop on the stop-sample cycle: no overrun
      for (int i = 0; i < 4; i++) send_frame(byte'(8'h10 + i), 1'b1, 1'b0, 1'b0);
      send_frame(8'h55, 1'b1, 1'b1, 1'b0);
      check("fullpop:count", 32'(cnt), 32'd4);
      check("fullpop:overrun", 32'(ovr), 32'h0);
      for (int i = 0; i < 3; i++) pop_one();
      check("fullpop:last", 32'(data), 32'h55);
      pop_one();

      // clear coinciding with a fresh overrun: the new error wins
      for (int i = 0; i < 4; i++) send_frame(byte'(8'h20 + i), 1'b1, 1'b0, 1'b0);
      send_frame(8'h77, 1'b1, 1'b0, 1'b1);
      check("clrwin:overrun", 32'(ovr), 32'h1);
      clear_errs();
      for (int i = 0; i < 4; i++) pop_one();

      // short glitch on the idle line
      tx = 1'b0;
      tick(6);
      tx = 1'b1;
      tick(40);
      expect_state("glitch");
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
      pop_one();

      // low stop bit
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check("badstop:frame_err", 32'(ferr), 32'(FRAMING));
      check("badstop:count", 32'(cnt), FRAMING ? 32'd0 : 32'd1);
      clear_errs();
      if (q.size() != 0) pop_one();

      // reset in the middle of bit 4 with the line held low afterwards
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      tx = 1'b0;
      tick(88);
      do_reset();
      tick(400);
      expect_state("midreset");
      check("midreset:irq", 32'(irq), 32'h0);
      $display("reset mid-frame count=%0d", cnt);
      tx = 1'b1;
      tick(20);
      expect_state("midreset_idle");
      send_frame(8'h96, 1'b1, 1'b0, 1'b0);
      pop_one();

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5)
            send_frame(byte'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
         else if (r <= 7) pop_one();
         else if (r == 8) clear_errs();
         else irq_probe(bit'($urandom_range(0, 1)));
      end
      while (q.size() != 0) pop_one();
      pop_one();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
